infer_sequencer: RTL
====================

INFER_SEQUENCER -- requirements
Module: infer_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the number of cycles a button level must be stable before it is accepted.
REQ-002 The block SHALL have parameter RST_CYCLES, default 2, giving the low-pulse width of draw_rstn and acc_rstn.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, giving the maximum number of COMPUTE cycles allowed before an error is raised.
REQ-004 The block SHALL have parameter RESULT_W, default 4, giving the width of the accelerator result.
REQ-005 The block SHALL have parameter HIST_DEPTH, default 4, giving the number of stored past results.
REQ-006 The block SHALL have parameter AUTO_CLEAR, default 0; when 1, SHOW returns to RESET_DRAW after SHOW_HOLD cycles.
REQ-007 The block SHALL have parameter SHOW_HOLD, default 50000000, giving the SHOW dwell in cycles when AUTO_CLEAR=1.
REQ-008 The block SHALL have ports, one per line (name, direction, width, meaning):
- sysClk  in  1  sole clock.
- iRst_n  in  1  reset, asynchronous and active-low.
- confirm  in  1  raw button, asynchronous to sysClk.
- clear  in  1  raw button, asynchronous to sysClk.
- acc_done  in  1  accelerator finished; level signal.
- acc_overflow  in  1  accelerator overflow flag; valid with acc_done.
- acc_result  in  RESULT_W  accelerator result; valid with acc_done.
- draw_ena  out  1  drawing-unit enable.
- draw_rstn  out  1  drawing-unit reset, active-low.
- acc_ena  out  1  accelerator enable.
- acc_rstn  out  1  accelerator reset, active-low.
- disp_ena  out  1  display enable.
- result  out  RESULT_W  latched result.
- overflow_o  out  1  latched overflow.
- history  out  HIST_DEPTH*RESULT_W  past results; the low slice holds the newest.
- hist_count  out  clog2(HIST_DEPTH+1)  number of valid history entries.
- busy  out  1  high in RESET_ACC and COMPUTE.
- timeout_err  out  1  high in ERROR.

Function
REQ-009 Each button SHALL pass through a 2-FF synchroniser, then a debouncer; the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-010 A press event SHALL be a one-cycle pulse on each rising edge of a debounced level.
REQ-011 The FSM SHALL have the states RESET_DRAW, DRAW, RESET_ACC, COMPUTE, SHOW and ERROR.
REQ-012 The FSM SHALL enter RESET_DRAW on the first clock after reset release.
REQ-013 RESET_DRAW: draw_rstn=0 for RST_CYCLES cycles, draw_ena=1, disp_ena=0, acc_ena=0, then DRAW.
REQ-014 DRAW: a clear press SHALL go to RESET_DRAW; a confirm press SHALL go to RESET_ACC; clear SHALL win when both occur in the same cycle.
REQ-015 RESET_ACC: acc_ena=1 and acc_rstn=0 for RST_CYCLES cycles, then COMPUTE with the timeout counter at 0.
REQ-016 COMPUTE: the timeout counter SHALL increment each cycle.
REQ-017 COMPUTE: on acc_done=1 the block SHALL latch result and overflow_o, shift result into history, increment hist_count (saturating at HIST_DEPTH), set disp_ena=1 and go to SHOW.
REQ-018 COMPUTE: at counter == TIMEOUT_CYCLES-1 without acc_done, the block SHALL go to ERROR with acc_ena=0; acc_done in that same cycle SHALL win over timeout.
REQ-019 COMPUTE: a clear press SHALL abort to RESET_DRAW with acc_ena=0, leaving result and history unchanged; clear SHALL win over a simultaneous acc_done.
REQ-020 SHOW: a clear press SHALL go to RESET_DRAW; with AUTO_CLEAR=1, after SHOW_HOLD cycles, the block SHALL also go to RESET_DRAW; result, overflow_o and history SHALL persist across RESET_DRAW.
REQ-021 ERROR: timeout_err=1; only a clear press SHALL exit, to RESET_DRAW, clearing timeout_err.
REQ-022 Confirm presses outside DRAW SHALL be ignored, neither queued nor remembered.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 Asserting iRst_n low at any time, including mid-COMPUTE, SHALL immediately force: state=RESET_DRAW-pending; draw_ena=0, draw_rstn=1, acc_ena=0, acc_rstn=1, disp_ena=0; result=0, overflow_o=0, history=0, hist_count=0; busy=0, timeout_err=0; all counters and debouncer state cleared.

Structure
REQ-025 A shared package infer_seq_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-026 A sub-module btn_debounce (synchroniser, debouncer, edge pulse; parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification
REQ-027 With DEBOUNCE_CYCLES=4, a 3-cycle confirm glitch in DRAW -> no state change; a 10-cycle press -> RESET_ACC, acc_rstn low for exactly 2 cycles.
REQ-028 In COMPUTE, acc_done=1 with acc_result=7 and acc_overflow=1 -> result=7, overflow_o=1, disp_ena=1, hist_count=1, history[3:0]=7.
REQ-029 After five results 1,2,3,4,5 -> history={2,3,4,5} (5 in the low slice), hist_count=4 (saturated).
REQ-030 With TIMEOUT_CYCLES=100 and no acc_done -> ERROR after 100 COMPUTE cycles, timeout_err=1, acc_ena=0; a clear press -> RESET_DRAW, timeout_err=0.
REQ-031 acc_done at cycle 99 with TIMEOUT_CYCLES=100 -> SHOW, no error; clear and acc_done in the same cycle -> RESET_DRAW, history unchanged.
REQ-032 iRst_n pulsed low mid-COMPUTE -> all outputs at reset values asynchronously; the block re-enters RESET_DRAW one cycle after release.

Source files
------------

// File: rtl/infer_seq_pkg.sv
`default_nettype none
// ---- infer_seq_pkg : state encoding and default parameters of the inference sequencer ----
// ---- Rev 1.0 ----
package infer_seq_pkg;

    typedef enum logic [2:0] {
        ST_PEND       = 3'd0,
        ST_RESET_DRAW = 3'd1,
        ST_DRAW       = 3'd2,
        ST_RESET_ACC  = 3'd3,
        ST_COMPUTE    = 3'd4,
        ST_SHOW       = 3'd5,
        ST_ERROR      = 3'd6
    } seq_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_RST_CYCLES      = 2;
    localparam int DEF_TIMEOUT_CYCLES  = 1000000;
    localparam int DEF_RESULT_W        = 4;
    localparam int DEF_HIST_DEPTH      = 4;
    localparam int DEF_AUTO_CLEAR      = 0;
    localparam int DEF_SHOW_HOLD       = 50000000;

    // One shared dwell counter; wide enough for the largest timeout/hold.
    localparam int CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ---- btn_debounce : 2-FF synchroniser, stability debouncer, rising-edge press pulse ----
// ---- Rev 1.0 ----
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The counter tracks consecutive samples that disagree with the accepted level.
    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/infer_sequencer.sv
`default_nettype none
// ---- infer_sequencer : draw -> accelerate -> show sequencer with result history and timeout ----
// ---- Rev 1.0 ----
module infer_sequencer
    import infer_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RST_CYCLES      = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int RESULT_W        = DEF_RESULT_W,
    parameter int HIST_DEPTH      = DEF_HIST_DEPTH,
    parameter int AUTO_CLEAR      = DEF_AUTO_CLEAR,
    parameter int SHOW_HOLD       = DEF_SHOW_HOLD
) (
    input  logic                           sysClk,
    input  logic                           iRst_n,
    input  logic                           confirm,
    input  logic                           clear,
    input  logic                           acc_done,
    input  logic                           acc_overflow,
    input  logic [RESULT_W-1:0]            acc_result,
    output logic                           draw_ena,
    output logic                           draw_rstn,
    output logic                           acc_ena,
    output logic                           acc_rstn,
    output logic                           disp_ena,
    output logic [RESULT_W-1:0]            result,
    output logic                           overflow_o,
    output logic [HIST_DEPTH*RESULT_W-1:0] history,
    output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int HIST_W = HIST_DEPTH * RESULT_W;
    localparam int HC_W   = $clog2(HIST_DEPTH + 1);

    logic              confirm_press;
    logic              clear_press;

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic              draw_ena_q, draw_ena_d;
    logic              draw_rstn_q, draw_rstn_d;
    logic              acc_ena_q, acc_ena_d;
    logic              acc_rstn_q, acc_rstn_d;
    logic              disp_ena_q, disp_ena_d;
    logic              busy_q, busy_d;
    logic              tmo_err_q, tmo_err_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
        .clk_i   (sysClk),
        .rst_ni  (iRst_n),
        .btn_i   (confirm),
        .press_o (confirm_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk_i   (sysClk),
        .rst_ni  (iRst_n),
        .btn_i   (clear),
        .press_o (clear_press)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        result_d = result_q;
        ovf_d    = ovf_q;
        hist_d   = hist_q;
        hcnt_d   = hcnt_q;

        unique case (state_q)
            ST_PEND:       state_d = ST_RESET_DRAW;
            ST_RESET_DRAW: if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_DRAW;
            ST_DRAW: begin
                if (clear_press)        state_d = ST_RESET_DRAW;
                else if (confirm_press) state_d = ST_RESET_ACC;
            end
            ST_RESET_ACC:  if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_COMPUTE;
            ST_COMPUTE: begin
                // Priority: user abort, then completion, then timeout.
                if (clear_press) begin
                    state_d = ST_RESET_DRAW;
                end else if (acc_done) begin
                    state_d  = ST_SHOW;
                    result_d = acc_result;
                    ovf_d    = acc_overflow;
                    hist_d   = (hist_q << RESULT_W) | HIST_W'(acc_result);
                    hcnt_d   = (hcnt_q == HC_W'(HIST_DEPTH)) ? hcnt_q : hcnt_q + HC_W'(1);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SHOW: begin
                if (clear_press) state_d = ST_RESET_DRAW;
                else if ((AUTO_CLEAR != 0) && (cnt_q == CNT_W'(SHOW_HOLD - 1)))
                    state_d = ST_RESET_DRAW;
            end
            ST_ERROR:      if (clear_press) state_d = ST_RESET_DRAW;
            default:       state_d = ST_RESET_DRAW;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so the registers line up with state_q.
        draw_ena_d  = (state_d == ST_RESET_DRAW) || (state_d == ST_DRAW);
        draw_rstn_d = (state_d != ST_RESET_DRAW);
        acc_ena_d   = (state_d == ST_RESET_ACC) || (state_d == ST_COMPUTE);
        acc_rstn_d  = (state_d != ST_RESET_ACC);
        disp_ena_d  = (state_d == ST_SHOW);
        busy_d      = (state_d == ST_RESET_ACC) || (state_d == ST_COMPUTE);
        tmo_err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge sysClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= ST_PEND;
            cnt_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            hist_q      <= '0;
            hcnt_q      <= '0;
            draw_ena_q  <= 1'b0;
            draw_rstn_q <= 1'b1;
            acc_ena_q   <= 1'b0;
            acc_rstn_q  <= 1'b1;
            disp_ena_q  <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            hist_q      <= hist_d;
            hcnt_q      <= hcnt_d;
            draw_ena_q  <= draw_ena_d;
            draw_rstn_q <= draw_rstn_d;
            acc_ena_q   <= acc_ena_d;
            acc_rstn_q  <= acc_rstn_d;
            disp_ena_q  <= disp_ena_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign draw_ena    = draw_ena_q;
    assign draw_rstn   = draw_rstn_q;
    assign acc_ena     = acc_ena_q;
    assign acc_rstn    = acc_rstn_q;
    assign disp_ena    = disp_ena_q;
    assign result      = result_q;
    assign overflow_o  = ovf_q;
    assign history     = hist_q;
    assign hist_count  = hcnt_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_err_q;

endmodule
`default_nettype wire
